// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state encoding and default busy lengths. Also imported by the
// control decoder so both sides agree on the op field.
package muldiv_pkg;

  // Op field presented by the E stage; 9..15 behave as OP_NONE
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;
  localparam int unsigned CNT_W          = 4;

  // Multiply ops (signed or unsigned)
  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  // Divide ops (signed or unsigned)
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_div.sv
// Combinational 32-bit divider for the muldiv unit. Signed mode gives a
// quotient truncated toward zero and a remainder carrying the dividend's
// sign. Divide-by-zero is flagged; quotient/remainder are then don't-care.
module muldiv_div
  import muldiv_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_signed,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem,
  output logic        o_divzero
);

  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_divisor;
  logic [31:0] w_uquot;
  logic [31:0] w_urem;

  // Magnitude divide, then restore signs; divisor forced to 1 on zero
  // so the arithmetic stays well defined
  always_comb begin
    o_divzero = (i_b == '0);
    w_neg_a   = i_signed & i_a[31];
    w_neg_b   = i_signed & i_b[31];
    w_mag_a   = w_neg_a ? (~i_a + 32'd1) : i_a;
    w_mag_b   = w_neg_b ? (~i_b + 32'd1) : i_b;
    w_divisor = o_divzero ? 32'd1 : w_mag_b;
    w_uquot   = w_mag_a / w_divisor;
    w_urem    = w_mag_a % w_divisor;
    o_quot    = (w_neg_a ^ w_neg_b) ? (~w_uquot + 32'd1) : w_uquot;
    o_rem     = w_neg_a ? (~w_urem + 32'd1) : w_urem;
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit. Multi-cycle mult/multu/div/divu with a
// fixed busy length, plus mfhi/mflo reads and mthi/mtlo writes.
// Optional feature: define MULDIV_DIVZERO_HOLD_EN to leave HI/LO
// untouched on divide-by-zero (default writes HI=a, LO=all ones).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = muldiv_pkg::MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = muldiv_pkg::DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic        op_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic             r_signed;

  logic             w_accept;
  logic             w_acc_mul;
  logic             w_acc_div;
  logic             w_mthi_we;
  logic             w_mtlo_we;
  logic             w_done;
  logic [63:0]      w_ext_a;
  logic [63:0]      w_ext_b;
  logic [63:0]      w_prod;
  logic [31:0]      w_quot;
  logic [31:0]      w_rem;
  logic             w_divzero;

  muldiv_div u_div (
    .i_a       (r_a),
    .i_b       (r_b),
    .i_signed  (r_signed),
    .o_quot    (w_quot),
    .o_rem     (w_rem),
    .o_divzero (w_divzero)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: leave MUL/DIV on the cycle the counter shows 1
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_acc_mul)      w_state_nxt = ST_MUL;
        else if (w_acc_div) w_state_nxt = ST_DIV;
      end
      ST_MUL, ST_DIV: begin
        if (r_cnt == CNT_W'(1)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output/decode: acceptance strobes and completion flag
  always_comb begin
    w_accept  = op_valid & ~r_busy;
    w_acc_mul = w_accept & is_mul_op(op);
    w_acc_div = w_accept & is_div_op(op);
    w_mthi_we = w_accept & (op == OP_MTHI);
    w_mtlo_we = w_accept & (op == OP_MTLO);
    start     = w_acc_mul | w_acc_div;
    w_done    = (r_state != ST_IDLE) & (r_cnt == CNT_W'(1));
  end

  // Busy counter and registered busy flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      if (w_acc_mul)                r_cnt <= MUL_LD;
      else if (w_acc_div)           r_cnt <= DIV_LD;
      else if (r_state != ST_IDLE)  r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Operand capture at acceptance; later a/b changes are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
    end else if (start) begin
      r_a      <= a;
      r_b      <= b;
      r_signed <= (op == OP_MULT) || (op == OP_DIV);
    end
  end

  // Sign/zero-extend to 64 bits so one unsigned multiply covers both modes
  always_comb begin
    w_ext_a = {{32{r_signed & r_a[31]}}, r_a};
    w_ext_b = {{32{r_signed & r_b[31]}}, r_b};
    w_prod  = w_ext_a * w_ext_b;
  end

  // HI/LO update: operation completion or accepted mthi/mtlo
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      if (r_state == ST_MUL) begin
        r_hi <= w_prod[63:32];
        r_lo <= w_prod[31:0];
      end else if (w_divzero) begin
`ifdef MULDIV_DIVZERO_HOLD_EN
        r_hi <= r_hi;
        r_lo <= r_lo;
`else
        r_hi <= r_a;
        r_lo <= '1;
`endif
      end else begin
        r_hi <= w_rem;
        r_lo <= w_quot;
      end
    end else if (w_mthi_we) begin
      r_hi <= a;
    end else if (w_mtlo_we) begin
      r_lo <= a;
    end
  end

  // Read port reflects pre-edge register values
  always_comb begin
    rdata = '0;
    if (op == OP_MFHI)      rdata = r_hi;
    else if (op == OP_MFLO) rdata = r_lo;
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of expected {hi,lo}
// pushed at issue, popped when the operation completes.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned MULC = 5;
  localparam int unsigned DIVC = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  op;
  logic        op_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          cyc_acc  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] q_exp[$];

  muldiv_unit #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .op_valid (op_valid),
    .a        (a),
    .b        (b),
    .start    (start),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .rdata    (rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: returns new {hi,lo}
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] ch,
                                        input logic [31:0] cl);
    int          sx, sy, q, r;
    longint      sp;
    logic [63:0] res;
    sx  = x;
    sy  = y;
    res = {ch, cl};
    case (o)
      4'd1: begin sp = longint'(sx) * longint'(sy); res = sp; end
      4'd2: res = {32'b0, x} * {32'b0, y};
      4'd3, 4'd4: begin
        if (y == 0) begin
`ifdef MULDIV_DIVZERO_HOLD_EN
          res = {ch, cl};
`else
          res = {x, 32'hFFFFFFFF};
`endif
        end else if (o == 4'd3) begin
          q = sx / sy;
          r = sx % sy;
          res = {r, q};
        end else begin
          res = {x % y, x / y};
        end
      end
      4'd7: res = {x, cl};
      4'd8: res = {ch, x};
      default: res = {ch, cl};
    endcase
    return res;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input string tag);
    logic [63:0] e;
    logic [31:0] e_rd;
    logic        md, mul;
    md   = (o >= 4'd1) && (o <= 4'd4);
    mul  = (o == 4'd1) || (o == 4'd2);
    e_rd = (o == 4'd5) ? m_hi : (o == 4'd6) ? m_lo : 32'd0;
    @(negedge clk);
    op = o; op_valid = 1'b1; a = x; b = y;
    #1;
    check({tag, "_busy_pre"}, busy, 0);
    check({tag, "_start"}, start, md);
    check({tag, "_rdata"}, rdata, e_rd);
    e = model(o, x, y, m_hi, m_lo);
    m_hi = e[63:32];
    m_lo = e[31:0];
    q_exp.push_back(e);
    @(posedge clk); #1;
    cyc_acc = cyc;
    op_valid = 1'b0; op = 4'd0; a = $urandom; b = $urandom;
    if (md) begin
      wait_idle();
      check({tag, "_cycles"}, cyc - cyc_acc, mul ? MULC : DIVC);
    end
    e = q_exp.pop_front();
    check({tag, "_hilo"}, {hi, lo}, e);
  endtask

  initial begin
    logic [63:0] e;
    logic [31:0] ph, pl, x, y;
    logic [3:0]  o;

    reset = 1'b1; op_valid = 1'b0; op = 4'd0; a = '0; b = '0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_start", start, 0);
    #5 reset = 1'b0;

    // First op lands on the first rising edge after release
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3, "mult");
    check("mult_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2, "multu");
    check("multu_const", {hi, lo}, 64'h00000001_FFFFFFFE);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, "div");
    check("div_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    issue(OP_DIVU, 32'd7, 32'd2, "divu");
    check("divu_const", {hi, lo}, 64'h00000001_00000003);
    issue(OP_MFHI, 32'd0, 32'd0, "mfhi");
    issue(OP_MFLO, 32'd0, 32'd0, "mflo");
    issue(4'd9, 32'h1234, 32'h5678, "op9");
    issue(OP_MTHI, 32'hCAFE0001, 32'd0, "mthi");
    issue(OP_MTLO, 32'hBEEF0002, 32'd0, "mtlo");

    // Ops issued while a divide is in flight are ignored
    ph = m_hi; pl = m_lo;
    @(negedge clk);
    op = OP_DIV; op_valid = 1'b1; a = 32'd100; b = 32'd7;
    #1;
    check("ign_div_start", start, 1);
    e = model(OP_DIV, 32'd100, 32'd7, m_hi, m_lo);
    m_hi = e[63:32]; m_lo = e[31:0];
    q_exp.push_back(e);
    @(posedge clk); #1;
    cyc_acc = cyc;
    op_valid = 1'b0;
    @(negedge clk);
    op = OP_MTHI; op_valid = 1'b1; a = 32'd5;
    #1;
    check("ign_mthi_start", start, 0);
    @(negedge clk);
    op = OP_MULT; a = 32'd3; b = 32'd4;
    #1;
    check("ign_mult_start", start, 0);
    check("ign_hilo_mid", {hi, lo}, {ph, pl});
    @(negedge clk);
    op_valid = 1'b0; op = 4'd0;
    wait_idle();
    check("ign_cycles", cyc - cyc_acc, DIVC);
    e = q_exp.pop_front();
    check("ign_hilo", {hi, lo}, e);

    // Divide by zero
    issue(OP_MTHI, 32'd1, 32'd0, "dz_mthi");
    issue(OP_MTLO, 32'd2, 32'd0, "dz_mtlo");
    issue(OP_DIV, 32'd9, 32'd0, "dz_div");
`ifdef MULDIV_DIVZERO_HOLD_EN
    check("dz_const", {hi, lo}, 64'h00000001_00000002);
`else
    check("dz_const", {hi, lo}, 64'h00000009_FFFFFFFF);
`endif
    issue(OP_DIVU, 32'd11, 32'd0, "dz_divu");

    // Reset in busy cycle 3 of a divide discards the result
    issue(OP_DIVU, 32'd100, 32'd7, "pre_rst");
    @(negedge clk);
    op = OP_DIV; op_valid = 1'b1; a = 32'd50; b = 32'd3;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("rst_mid_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    q_exp.delete();
    @(negedge clk);
    reset = 1'b0;
    issue(OP_MULT, 32'd6, 32'd7, "post_rst");

    // Random mix
    for (int i = 0; i < 16; i++) begin
      o = 4'($urandom_range(1, 8));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 5) == 0) y = '0;
      if (o == OP_DIV && x == 32'h80000000 && y == 32'hFFFFFFFF) y = 32'd1;
      issue(o, x, y, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
